// File: rtl/dec_pkg.sv
// Shared definitions for the strobe-decoder family: FSM state encoding and default widths.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int SEL_W_DEF   = 3;
  localparam int DWELL_W_DEF = 8;
  localparam int DEPTH_DEF   = 4;

endpackage

// File: rtl/dec3_8_strobe_if.sv
// Upstream code handshake: producer drives valid/code, the decoder returns ready.
interface dec3_8_strobe_if #(
  parameter int SEL_W = 3
);
  logic             in_valid;
  logic [SEL_W-1:0] in_code;
  logic             in_ready;

  modport master (output in_valid, output in_code, input  in_ready);
  modport slave  (input  in_valid, input  in_code, output in_ready);
endinterface

// File: rtl/dec3_8_strobe_chk.sv
// Protocol properties of the strobe decoder: strobe is one-hot or zero and agrees with y_valid.
module dec3_8_strobe_chk #(
  parameter int N_OUT = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             in_ready,
  input logic             y_valid,
  input logic [N_OUT-1:0] y
);

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(y));

  a_valid_matches_y: assert property (@(posedge clk) disable iff (rst)
    y_valid == (y != {N_OUT{1'b0}}));

  a_no_ready_in_reset: assert property (@(posedge clk) rst |-> !in_ready);

endmodule

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO with show-ahead read data; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against occupancy so the FIFO never over/underflows.
  always_comb begin
    full      = (count_r == (AW+1)'(DEPTH));
    empty     = (count_r == {(AW+1){1'b0}});
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    dout      = mem_r[rd_ptr_r];
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dec3_8_strobe.sv
// Sequenced 3-to-8 decoder: queues codes and drives each as a dwell-length one-hot strobe
// separated by one all-zero break-before-make cycle.
module dec3_8_strobe
  import dec_pkg::*;
#(
  parameter int  SEL_W   = SEL_W_DEF,
  parameter int  DEPTH   = DEPTH_DEF,
  parameter int  DWELL_W = DWELL_W_DEF,
  localparam int N_OUT   = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [DWELL_W-1:0] dwell,
  dec3_8_strobe_if.slave     bus,
  output logic [N_OUT-1:0]   y,
  output logic [SEL_W-1:0]   y_code,
  output logic               y_valid,
  output logic               busy
);
  localparam logic [N_OUT-1:0] Y_ONE = {{(N_OUT-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [N_OUT-1:0]   y_r;
  logic [SEL_W-1:0]   y_code_r;
  logic               y_valid_r;
  logic               rdy_en_r;

  logic               in_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [SEL_W-1:0]   head_s;
  logic [DWELL_W-1:0] dwell_m1_s;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (SEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (bus.in_code),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Handshake, pop decision and dwell reload value (dwell of 0 behaves as 1).
  always_comb begin
    in_ready_s = rdy_en_r & ~full_s;
    push_s     = bus.in_valid & in_ready_s;
    if (enb && !empty_s && ((state_r == IDLE) || (state_r == GAP))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (dwell == {DWELL_W{1'b0}}) begin
      dwell_m1_s = {DWELL_W{1'b0}};
    end else begin
      dwell_m1_s = dwell - DWELL_W'(1);
    end
  end

  assign bus.in_ready = in_ready_s;

  // Strobe sequencer: FSM, dwell counter and registered one-hot outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {DWELL_W{1'b0}};
      y_r       <= {N_OUT{1'b0}};
      y_code_r  <= {SEL_W{1'b0}};
      y_valid_r <= 1'b0;
      rdy_en_r  <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (!enb) begin
        // Abort the in-flight strobe; queued codes stay in the FIFO.
        state_r   <= IDLE;
        cnt_r     <= {DWELL_W{1'b0}};
        y_r       <= {N_OUT{1'b0}};
        y_valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE, GAP: begin
            if (pop_s) begin
              state_r   <= DRIVE;
              y_r       <= Y_ONE << head_s;
              y_code_r  <= head_s;
              y_valid_r <= 1'b1;
              cnt_r     <= dwell_m1_s;
            end else begin
              state_r   <= IDLE;
              y_r       <= {N_OUT{1'b0}};
              y_valid_r <= 1'b0;
            end
          end
          DRIVE: begin
            if (cnt_r == {DWELL_W{1'b0}}) begin
              state_r   <= GAP;
              y_r       <= {N_OUT{1'b0}};
              y_valid_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r - DWELL_W'(1);
            end
          end
          default: begin
            state_r   <= IDLE;
            cnt_r     <= {DWELL_W{1'b0}};
            y_r       <= {N_OUT{1'b0}};
            y_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign y       = y_r;
  assign y_code  = y_code_r;
  assign y_valid = y_valid_r;
  assign busy    = (state_r != IDLE) | ~empty_s;

endmodule

// File: tb/tb_dec3_8_strobe.sv
// Directed bench for dec3_8_strobe: table of single strobes plus hand-written multi-cycle sequences.
module tb_dec3_8_strobe;
  import dec_pkg::*;

  logic       clk;
  logic       rst;
  logic       enb;
  logic [7:0] dwell;
  logic [7:0] y;
  logic [2:0] y_code;
  logic       y_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] code;
    logic [7:0] dwell;
    logic [7:0] exp_y;
    int         len;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] seq_exp [9];
  logic [7:0] seq_got [9];

  dec3_8_strobe_if #(.SEL_W(3)) bus ();

  dec3_8_strobe #(
    .SEL_W   (3),
    .DEPTH   (4),
    .DWELL_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enb     (enb),
    .dwell   (dwell),
    .bus     (bus.slave),
    .y       (y),
    .y_code  (y_code),
    .y_valid (y_valid),
    .busy    (busy)
  );

  dec3_8_strobe_chk #(.N_OUT(8)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_ready (bus.in_ready),
    .y_valid  (y_valid),
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] code);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("push_ready", {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready) begin
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_strobe(input string nm, input logic [7:0] ey, input logic [2:0] ec, input int len);
    tick();
    check({nm, "_y"}, {24'd0, y}, {24'd0, ey});
    check({nm, "_code"}, {29'd0, y_code}, {29'd0, ec});
    check({nm, "_valid"}, {31'd0, y_valid}, 32'd1);
    for (int i = 1; i < len; i++) begin
      tick();
      check({nm, "_hold"}, {24'd0, y}, {24'd0, ey});
    end
    tick();
    check({nm, "_gap"}, {24'd0, y}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'd5, 8'd3, 8'h20, 3};
    vecs[1] = '{3'd2, 8'd0, 8'h04, 1};
    vecs[2] = '{3'd0, 8'd1, 8'h01, 1};
    vecs[3] = '{3'd7, 8'd2, 8'h80, 2};
    vecs[4] = '{3'd3, 8'd4, 8'h08, 4};
    vecs[5] = '{3'd6, 8'd1, 8'h40, 1};
    vecs[6] = '{3'd1, 8'd2, 8'h02, 2};
    vecs[7] = '{3'd4, 8'd0, 8'h10, 1};
    seq_exp = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00, 8'h08, 8'h08, 8'h00};

    rst          = 1'b1;
    enb          = 1'b0;
    dwell        = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_code  = 3'd0;

    // Reset state
    #1;
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_y_code", {29'd0, y_code}, 32'd0);
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("rel_in_ready_pre_edge", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single strobes from idle, one per table row
    enb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dwell = vecs[i].dwell;
      push(vecs[i].code);
      expect_strobe("vec", vecs[i].exp_y, vecs[i].code, vecs[i].len);
      tick();
      check("vec_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Back-to-back codes 0,7,3 with dwell 2
    dwell = 8'd2;
    fork
      begin
        push(3'd0);
        push(3'd7);
        push(3'd3);
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
          tick();
          seq_got[i] = y;
        end
      end
    join
    for (int i = 0; i < 9; i++) begin
      check("b2b_y", {24'd0, seq_got[i]}, {24'd0, seq_exp[i]});
    end
    tick();
    check("b2b_busy", {31'd0, busy}, 32'd0);

    // Fill FIFO with enb low, then release in FIFO order
    enb   = 1'b0;
    dwell = 8'd1;
    push(3'd1);
    push(3'd4);
    push(3'd6);
    push(3'd2);
    check("fill_y", {24'd0, y}, 32'd0);
    check("fill_full", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd5;
    tick();
    check("fill_stall5", {31'd0, bus.in_ready}, 32'd0);
    bus.in_code = 3'd7;
    tick();
    check("fill_stall6", {31'd0, bus.in_ready}, 32'd0);
    check("fill_y_idle", {24'd0, y}, 32'd0);
    bus.in_valid = 1'b0;
    check("fill_busy", {31'd0, busy}, 32'd1);
    enb = 1'b1;
    expect_strobe("drain1", 8'h02, 3'd1, 1);
    expect_strobe("drain4", 8'h10, 3'd4, 1);
    expect_strobe("drain6", 8'h40, 3'd6, 1);
    expect_strobe("drain2", 8'h04, 3'd2, 1);
    tick();
    check("drain_busy", {31'd0, busy}, 32'd0);

    // Drop enb in cycle 2 of a dwell-5 strobe on code 4
    dwell = 8'd5;
    push(3'd4);
    tick();
    check("abort_c1", {24'd0, y}, 32'h10);
    push(3'd1);
    check("abort_c2", {24'd0, y}, 32'h10);
    enb = 1'b0;
    tick();
    check("abort_y", {24'd0, y}, 32'd0);
    check("abort_valid", {31'd0, y_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_hold_y", {24'd0, y}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd1);
    end
    dwell = 8'd2;
    enb   = 1'b1;
    expect_strobe("resume1", 8'h02, 3'd1, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_replay_y", {24'd0, y}, 32'd0);
    end
    check("resume_busy", {31'd0, busy}, 32'd0);

    // Reset mid-strobe with three codes queued
    dwell = 8'd8;
    push(3'd3);
    push(3'd5);
    push(3'd6);
    push(3'd7);
    check("mid_drive", {24'd0, y}, 32'h08);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_y", {24'd0, y}, 32'd0);
    check("arst_valid", {31'd0, y_valid}, 32'd0);
    check("arst_code", {29'd0, y_code}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("arst_ready_edge", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_y", {24'd0, y}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
